// File: rtl/ra_pkg.sv
// Shared types for the RA prefetch controller: FSM encoding, latched tile request, perf width.
package ra_pkg;

    localparam int RA_PERF_W  = 32;
    localparam int RA_ADDR_W  = 32;
    localparam int RA_COORD_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DATA,
        SWAP_WAIT,
        SWAP
    } ra_pf_state_t;

    typedef struct packed {
        logic [RA_COORD_W-1:0] x0;
        logic [RA_COORD_W-1:0] y0;
        logic [RA_ADDR_W-1:0]  base;
        logic [RA_COORD_W-1:0] stride;
    } ra_tile_req_t;

endpackage

// File: rtl/ra_row_addr_gen.sv
// Row start address: base + (y0 + row) * stride + x0, wrapping modulo 2^ADDR_W.
// Kept in its own module so the multiplier can be retimed or pipelined in isolation.
module ra_row_addr_gen #(
    parameter int ADDR_W  = 32,
    parameter int COORD_W = 12,
    parameter int ROW_W   = 4
) (
    input  logic [ADDR_W-1:0]  base_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] stride_i,
    input  logic [ROW_W-1:0]   row_i,
    output logic [ADDR_W-1:0]  addr_o
);

    logic [ADDR_W-1:0] line;

    always_comb begin
        line   = ADDR_W'(y0_i) + ADDR_W'(row_i);
        addr_o = base_i + line * ADDR_W'(stride_i) + ADDR_W'(x0_i);
    end

endmodule

// File: rtl/ra_prefetch_ctrl.sv
// Tile prefetch engine feeding the RA0/RA1 ping-pong buffer: one DRAM burst per row, then a bank swap.
// Define RA_PREFETCH_PERF_EN to add the saturating perf_fill_cycles / perf_stall_cycles outputs.
module ra_prefetch_ctrl
    import ra_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int W       = 16,
    parameter int H       = 16,
    parameter int ADDR_W  = RA_ADDR_W,
    parameter int COORD_W = RA_COORD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tile_req_valid,
    output logic                     tile_req_ready,
    input  logic [COORD_W-1:0]       tile_x0,
    input  logic [COORD_W-1:0]       tile_y0,
    input  logic [ADDR_W-1:0]        frame_base,
    input  logic [COORD_W-1:0]       frame_stride,
    output logic                     dram_req_valid,
    input  logic                     dram_req_ready,
    output logic [ADDR_W-1:0]        dram_req_addr,
    output logic [$clog2(W+1)-1:0]   dram_req_len,
    input  logic                     dram_rd_valid,
    output logic                     dram_rd_ready,
    input  logic [DATA_W-1:0]        dram_rd_data,
    output logic                     start_fill,
    output logic                     wr_en,
    output logic [$clog2(W*H)-1:0]   wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     tile_valid,
    input  logic                     tile_release,
    output logic                     busy
`ifdef RA_PREFETCH_PERF_EN
    ,
    output logic [RA_PERF_W-1:0]     perf_fill_cycles,
    output logic [RA_PERF_W-1:0]     perf_stall_cycles
`endif
);

    localparam int LEN_W = $clog2(W+1);
    localparam int WA_W  = $clog2(W*H);
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;

    ra_pf_state_t      state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    ra_tile_req_t      req_q, req_d;
    logic              wr_en_q, wr_en_d;
    logic [WA_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              tile_valid_q, tile_valid_d;
    logic [ADDR_W-1:0] row_addr;

    ra_row_addr_gen #(
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W),
        .ROW_W   (ROW_W)
    ) u_row_addr_gen (
        .base_i   (req_q.base),
        .x0_i     (req_q.x0),
        .y0_i     (req_q.y0),
        .stride_i (req_q.stride),
        .row_i    (row_q),
        .addr_o   (row_addr)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        req_d        = req_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        tile_valid_d = tile_valid_q;

        // A release while a finished fill waits hands the bank straight over, so tile_valid never dips.
        if (tile_release && state_q != SWAP_WAIT)
            tile_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tile_req_valid) begin
                    req_d.x0     = tile_x0;
                    req_d.y0     = tile_y0;
                    req_d.base   = frame_base;
                    req_d.stride = frame_stride;
                    row_d        = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (dram_req_ready) begin
                    col_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (dram_rd_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = WA_W'(row_q) * WA_W'(W) + WA_W'(col_q);
                    wr_data_d = dram_rd_data;
                    col_d     = col_q + 1'b1;
                    if (col_q == COL_W'(W-1)) begin
                        if (row_q == ROW_W'(H-1)) begin
                            state_d = SWAP_WAIT;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end
            end
            SWAP_WAIT: begin
                if (!tile_valid_q || tile_release)
                    state_d = SWAP;
            end
            SWAP: begin
                tile_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            req_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            tile_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            req_q        <= req_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            tile_valid_q <= tile_valid_d;
        end
    end

    assign tile_req_ready = (state_q == IDLE);
    assign dram_req_valid = (state_q == REQ);
    assign dram_req_addr  = dram_req_valid ? row_addr : '0;
    assign dram_req_len   = dram_req_valid ? LEN_W'(W) : '0;
    assign dram_rd_ready  = (state_q == DATA);
    assign start_fill     = (state_q == SWAP);
    assign busy           = (state_q != IDLE);
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign tile_valid     = tile_valid_q;

`ifdef RA_PREFETCH_PERF_EN
    logic [RA_PERF_W-1:0] fill_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state_q == REQ || state_q == DATA) && fill_cnt_q != '1)
                fill_cnt_q <= fill_cnt_q + 1'b1;
            if (((state_q == DATA && !dram_rd_valid) || state_q == SWAP_WAIT) && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign perf_fill_cycles  = fill_cnt_q;
    assign perf_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ra_prefetch_ctrl.sv
// Self-checking bench for ra_prefetch_ctrl: a DRAM responder plus a tile-level reference model.
module tb_ra_prefetch_ctrl;

    localparam int DATA_W  = 16;
    localparam int W       = 16;
    localparam int H       = 16;
    localparam int ADDR_W  = 32;
    localparam int COORD_W = 12;
    localparam int NW      = W * H;

    logic                   clk;
    logic                   rst_n;
    logic                   tile_req_valid;
    logic                   tile_req_ready;
    logic [COORD_W-1:0]     tile_x0, tile_y0, frame_stride;
    logic [ADDR_W-1:0]      frame_base;
    logic                   dram_req_valid, dram_req_ready;
    logic [ADDR_W-1:0]      dram_req_addr;
    logic [$clog2(W+1)-1:0] dram_req_len;
    logic                   dram_rd_valid, dram_rd_ready;
    logic [DATA_W-1:0]      dram_rd_data;
    logic                   start_fill, wr_en, tile_valid, tile_release, busy;
    logic [$clog2(NW)-1:0]  wr_addr;
    logic [DATA_W-1:0]      wr_data;
`ifdef RA_PREFETCH_PERF_EN
    logic [31:0]            perf_fill_cycles, perf_stall_cycles;
`endif

    ra_prefetch_ctrl #(
        .DATA_W(DATA_W), .W(W), .H(H), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tile_req_valid (tile_req_valid),
        .tile_req_ready (tile_req_ready),
        .tile_x0        (tile_x0),
        .tile_y0        (tile_y0),
        .frame_base     (frame_base),
        .frame_stride   (frame_stride),
        .dram_req_valid (dram_req_valid),
        .dram_req_ready (dram_req_ready),
        .dram_req_addr  (dram_req_addr),
        .dram_req_len   (dram_req_len),
        .dram_rd_valid  (dram_rd_valid),
        .dram_rd_ready  (dram_rd_ready),
        .dram_rd_data   (dram_rd_data),
        .start_fill     (start_fill),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .tile_valid     (tile_valid),
        .tile_release   (tile_release),
        .busy           (busy)
`ifdef RA_PREFETCH_PERF_EN
        ,
        .perf_fill_cycles  (perf_fill_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (tile-level view of the transfer).
    int                m_x0, m_y0, m_stride;
    logic [31:0]       m_base;
    bit                active = 0, exp_sf = 0, tv_exp = 0;
    int                beats = 0, wr_idx = 0, reqs = 0, accepts = 0;
    int                sf_count = 0, sf_cyc = 0, last_wr_cyc = 0, cyc = 0;
    logic [DATA_W-1:0] dram_q[$];
    logic [DATA_W-1:0] exp_wq[$];
    logic [31:0]       req_log[$];
    bit                rand_mode = 0;
    int                req_stall_left = 0;
    bit                held = 0;
    logic [31:0]       held_addr;
    longint            exp_fill = 0, exp_stall = 0;
    bit                waiting_now, in_req, in_data, idle_exp, nsf, ntv;
    logic [31:0]       ea;
    logic [DATA_W-1:0] ew;

    // DRAM responder drives on the falling edge, then the monitor samples what the next rising edge will see.
    initial begin
        dram_req_ready = 1'b0;
        dram_rd_valid  = 1'b0;
        dram_rd_data   = '0;
        forever begin
            @(negedge clk);
            dram_req_ready = (req_stall_left == 0) && !(rand_mode && $urandom_range(0, 3) == 0);
            if (dram_q.size() > 0) begin
                dram_rd_valid = !(rand_mode && $urandom_range(0, 2) == 0);
                dram_rd_data  = dram_q[0];
            end else begin
                dram_rd_valid = rand_mode && ($urandom_range(0, 3) == 0);
                dram_rd_data  = 16'hDEAD;
            end
            #1;
            cyc++;

            in_data     = active && beats < NW && reqs * W > beats;
            in_req      = active && beats < NW && reqs * W == beats;
            waiting_now = active && wr_idx == NW && !exp_sf;
            idle_exp    = !active && !exp_sf;

            vectors++;
            if (start_fill !== exp_sf) begin
                miscompares++;
                $display("FAIL start_fill cyc %0d: got %b expected %b", cyc, start_fill, exp_sf);
            end
            vectors++;
            if (tile_valid !== tv_exp) begin
                miscompares++;
                $display("FAIL tile_valid cyc %0d: got %b expected %b", cyc, tile_valid, tv_exp);
            end
            vectors++;
            if (tile_req_ready !== idle_exp || busy !== !idle_exp) begin
                miscompares++;
                $display("FAIL ready_busy cyc %0d: got %b/%b expected %b/%b", cyc, tile_req_ready, busy, idle_exp, !idle_exp);
            end
            vectors++;
            if (dram_req_valid !== in_req || dram_rd_ready !== in_data) begin
                miscompares++;
                $display("FAIL phase cyc %0d: req_valid/rd_ready got %b/%b expected %b/%b", cyc, dram_req_valid, dram_rd_ready, in_req, in_data);
            end

            if (wr_en === 1'b1) begin
                vectors++;
                if (exp_wq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_wr cyc %0d: got wr_en with addr %0d, expected no write", cyc, wr_addr);
                end else begin
                    ew = exp_wq.pop_front();
                    if (wr_addr !== wr_idx[$clog2(NW)-1:0] || wr_data !== ew) begin
                        miscompares++;
                        $display("FAIL wr_beat cyc %0d: got addr %0d data %h expected addr %0d data %h", cyc, wr_addr, wr_data, wr_idx, ew);
                    end
                end
                wr_idx++;
                last_wr_cyc = cyc;
                waiting_now = active && wr_idx == NW && !exp_sf;
            end
            if (start_fill === 1'b1) begin
                sf_count++;
                sf_cyc = cyc;
            end

            if (!rst_n) begin
                exp_fill  = 0;
                exp_stall = 0;
                active    = 0;
                exp_sf    = 0;
                tv_exp    = 0;
                held      = 0;
                req_stall_left = 0;
                dram_q.delete();
                exp_wq.delete();
            end else begin
                exp_fill  += (in_req || in_data) ? 1 : 0;
                exp_stall += ((in_data && !dram_rd_valid) ? 1 : 0) + (waiting_now ? 1 : 0);

                if (dram_req_valid === 1'b1) begin
                    if (held) begin
                        vectors++;
                        if (dram_req_addr !== held_addr) begin
                            miscompares++;
                            $display("FAIL addr_hold cyc %0d: got %h expected %h", cyc, dram_req_addr, held_addr);
                        end
                    end
                    if (dram_req_ready) begin
                        ea = m_base + 32'((m_y0 + reqs) * m_stride + m_x0);
                        vectors++;
                        if (dram_req_addr !== ea || dram_req_len !== 5'(W)) begin
                            miscompares++;
                            $display("FAIL req_addr row %0d: got %h len %0d expected %h len %0d", reqs, dram_req_addr, dram_req_len, ea, W);
                        end
                        req_log.push_back(dram_req_addr);
                        for (int k = 0; k < W; k++) dram_q.push_back(DATA_W'($urandom));
                        reqs++;
                        held = 0;
                    end else begin
                        held      = 1;
                        held_addr = dram_req_addr;
                        if (req_stall_left > 0) req_stall_left--;
                    end
                end else begin
                    held = 0;
                end

                if (dram_rd_valid && dram_rd_ready === 1'b1) begin
                    if (dram_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL junk_beat cyc %0d: got beat accepted, expected ready low", cyc);
                    end else begin
                        exp_wq.push_back(dram_q.pop_front());
                    end
                    beats++;
                end

                if (tile_req_valid && tile_req_ready === 1'b1) begin
                    m_x0     = int'(tile_x0);
                    m_y0     = int'(tile_y0);
                    m_stride = int'(frame_stride);
                    m_base   = frame_base;
                    active   = 1;
                    beats    = 0;
                    wr_idx   = 0;
                    reqs     = 0;
                    req_log.delete();
                    accepts++;
                end

                nsf = waiting_now && (!tv_exp || tile_release);
                ntv = exp_sf ? 1'b1 : ((tile_release && !waiting_now) ? 1'b0 : tv_exp);
                if (exp_sf) active = 0;
                exp_sf = nsf;
                tv_exp = ntv;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_tile();
        tile_release = 1'b1;
        step();
        tile_release = 1'b0;
    endtask

    task automatic send_tile(input int x0, input int y0, input logic [31:0] base, input int stride);
        int a0;
        a0 = accepts;
        tile_x0        = COORD_W'(x0);
        tile_y0        = COORD_W'(y0);
        frame_base     = base;
        frame_stride   = COORD_W'(stride);
        tile_req_valid = 1'b1;
        for (int i = 0; i < 200 && accepts == a0; i++) step();
        tile_req_valid = 1'b0;
        vectors++;
        if (accepts == a0) begin
            miscompares++;
            $display("FAIL tile_accept: got no handshake in 200 cycles, expected one");
        end
    endtask

    task automatic wait_sf(input int sf0);
        for (int i = 0; i < 6000 && sf_count == sf0; i++) step();
        vectors++;
        if (sf_count != sf0 + 1) begin
            miscompares++;
            $display("FAIL start_fill_count: got %0d expected %0d", sf_count - sf0, 1);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef RA_PREFETCH_PERF_EN
        vectors++;
        if (perf_fill_cycles !== 32'(exp_fill) || perf_stall_cycles !== 32'(exp_stall)) begin
            miscompares++;
            $display("FAIL perf_%s: got fill %0d stall %0d expected fill %0d stall %0d", name, perf_fill_cycles, perf_stall_cycles, exp_fill, exp_stall);
        end
`else
        if (name.len() == 0) $display("perf check skipped");
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({tile_req_ready, busy, dram_req_valid, dram_rd_ready, start_fill, wr_en, tile_valid} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected %b", {tile_req_ready, busy, dram_req_valid, dram_rd_ready, start_fill, wr_en, tile_valid}, 7'b1000000);
        end
        vectors++;
        if (dram_req_addr !== '0 || dram_req_len !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: got addr %h len %0d wr_addr %0d wr_data %h expected all zero", dram_req_addr, dram_req_len, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_tile();
        int sf0;
        rand_mode = 0;
        sf0 = sf_count;
        send_tile(8, 4, 32'h1000, 64);
        wait_sf(sf0);
        vectors++;
        if (req_log.size() != H || wr_idx != NW) begin
            miscompares++;
            $display("FAIL single_counts: got %0d reqs %0d writes expected %0d reqs %0d writes", req_log.size(), wr_idx, H, NW);
        end else begin
            vectors++;
            if (req_log[0] !== 32'h1108 || req_log[H-1] !== 32'h14C8) begin
                miscompares++;
                $display("FAIL single_addrs: got first %h last %h expected 1108 14c8", req_log[0], req_log[H-1]);
            end
        end
        vectors++;
        if (sf_cyc - last_wr_cyc != 1) begin
            miscompares++;
            $display("FAIL single_swap_gap: got %0d expected 1", sf_cyc - last_wr_cyc);
        end
        vectors++;
        if (tile_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_tile_valid: got %b expected 1", tile_valid);
        end
        check_perf("single");
    endtask

    task automatic test_back_to_back();
        int sf0;
        sf0 = sf_count;
        send_tile($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom, $urandom_range(0, 4095));
        for (int i = 0; i < 3000 && wr_idx != NW; i++) step();
        repeat (10) step();
        vectors++;
        if (sf_count != sf0 || busy !== 1'b1 || tile_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_hold: got swaps %0d busy %b tile_valid %b expected 0 1 1", sf_count - sf0, busy, tile_valid);
        end
        tile_release = 1'b1;
        step();
        tile_release = 1'b0;
        vectors++;
        if (start_fill !== 1'b1 || tile_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_swap: got start_fill %b tile_valid %b expected 1 1", start_fill, tile_valid);
        end
        step();
        vectors++;
        if (start_fill !== 1'b0 || tile_valid !== 1'b1 || sf_count != sf0 + 1) begin
            miscompares++;
            $display("FAIL b2b_after: got start_fill %b tile_valid %b swaps %0d expected 0 1 1", start_fill, tile_valid, sf_count - sf0);
        end
    endtask

    task automatic test_release_idle();
        int sf0;
        release_tile();
        vectors++;
        if (tile_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL release_clear: got %b expected 0", tile_valid);
        end
        release_tile();
        vectors++;
        if (tile_valid !== 1'b0 || tile_req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL release_idle: got tv %b ready %b busy %b expected 0 1 0", tile_valid, tile_req_ready, busy);
        end
        sf0 = sf_count;
        send_tile($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom, $urandom_range(0, 4095));
        wait_sf(sf0);
        vectors++;
        if (sf_cyc - last_wr_cyc != 1 || tile_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL release_idle_swap: got gap %0d tv %b expected 1 1", sf_cyc - last_wr_cyc, tile_valid);
        end
    endtask

    task automatic test_stalls();
        int sf0;
        release_tile();
        rand_mode      = 1;
        req_stall_left = 5;
        sf0 = sf_count;
        send_tile($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom, $urandom_range(0, 4095));
        wait_sf(sf0);
        vectors++;
        if (wr_idx != NW || req_log.size() != H || exp_wq.size() != 0) begin
            miscompares++;
            $display("FAIL stall_counts: got %0d writes %0d reqs %0d pending expected %0d %0d 0", wr_idx, req_log.size(), exp_wq.size(), NW, H);
        end
        rand_mode = 0;
        check_perf("stall");
    endtask

    task automatic test_wrap();
        int sf0;
        release_tile();
        sf0 = sf_count;
        send_tile(5, 1, 32'hFFFF_FF00, 256);
        wait_sf(sf0);
        vectors++;
        if (req_log.size() < 2) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d reqs expected %0d", req_log.size(), H);
        end else if (req_log[0] !== 32'h0000_0005 || req_log[1] !== 32'h0000_0105) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h %h expected 00000005 00000105", req_log[0], req_log[1]);
        end
    endtask

    task automatic test_reset_mid_fill();
        int sf0;
        release_tile();
        sf0 = sf_count;
        send_tile($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom, $urandom_range(0, 4095));
        for (int i = 0; i < 3000 && beats < 7 * W + 3; i++) step();
        rst_n = 1'b0;
        step();
        vectors++;
        if (wr_en !== 1'b0 || start_fill !== 1'b0 || tile_valid !== 1'b0 || tile_req_ready !== 1'b1 || dram_rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midfill_reset: got wr_en %b sf %b tv %b ready %b rd_ready %b expected 0 0 0 1 0", wr_en, start_fill, tile_valid, tile_req_ready, dram_rd_ready);
        end
        rst_n = 1'b1;
        repeat (20) step();
        vectors++;
        if (sf_count != sf0) begin
            miscompares++;
            $display("FAIL midfill_no_swap: got %0d swaps expected 0", sf_count - sf0);
        end
        send_tile($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom, $urandom_range(0, 4095));
        wait_sf(sf0);
        vectors++;
        if (wr_idx != NW || req_log.size() != H) begin
            miscompares++;
            $display("FAIL midfill_refill: got %0d writes %0d reqs expected %0d %0d", wr_idx, req_log.size(), NW, H);
        end
        check_perf("midfill");
    endtask

    task automatic test_random_tiles();
        int sf0;
        rand_mode = 1;
        for (int t = 0; t < 4; t++) begin
            if (t != 2) release_tile();
            sf0 = sf_count;
            send_tile($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom, $urandom_range(0, 4095));
            if (t == 2) begin
                for (int i = 0; i < 4000 && wr_idx != NW; i++) step();
                repeat ($urandom_range(1, 8)) step();
                release_tile();
            end
            wait_sf(sf0);
            vectors++;
            if (wr_idx != NW || req_log.size() != H) begin
                miscompares++;
                $display("FAIL random_tile%0d: got %0d writes %0d reqs expected %0d %0d", t, wr_idx, req_log.size(), NW, H);
            end
        end
        rand_mode = 0;
        repeat (3) step();
        check_perf("random");
    endtask

    initial begin
        rst_n          = 1'b0;
        tile_req_valid = 1'b0;
        tile_release   = 1'b0;
        tile_x0        = '0;
        tile_y0        = '0;
        frame_base     = '0;
        frame_stride   = '0;
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_release_idle();
        test_stalls();
        test_wrap();
        test_reset_mid_fill();
        test_random_tiles();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ra_prefetch_ctrl.md
Name: ra_prefetch_ctrl

Overview:
Fetch engine that sits directly upstream of the RA0/RA1 ping-pong buffer. It accepts a reference-tile request (x0, y0, frame base, stride) and issues one DRAM read request per tile row. It converts the returned word stream into RA write strobes (wr_en/wr_addr/wr_data), then pulses start_fill to swap banks, which publishes the filled tile to the motion-compensation reader.
The bank protocol is fill-then-swap: writes target the current write bank, and start_fill makes that bank readable.

Parameters:
DATA_W, 16, pixel word width; matches RA buffer.
W, 16, tile width in words.
H, 16, tile height in rows.
ADDR_W, 32, DRAM word-address width.
COORD_W, 12, tile coordinate / stride width.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous active-low
tile_req_valid  input  1  tile request valid
tile_req_ready  output  1  high in IDLE only
tile_x0  input  COORD_W  tile left column (words)
tile_y0  input  COORD_W  tile top row
frame_base  input  ADDR_W  reference frame base word address
frame_stride  input  COORD_W  words per frame row
dram_req_valid  output  1  row read request valid
dram_req_ready  input  1  DRAM accepts request
dram_req_addr  output  ADDR_W  row start address
dram_req_len  output  $clog2(W+1)  burst length, always W
dram_rd_valid  input  1  return data valid
dram_rd_ready  output  1  high only in DATA state
dram_rd_data  input  DATA_W  return word
start_fill  output  1  one-cycle bank-swap pulse to RA
wr_en  output  1  RA write strobe
wr_addr  output  $clog2(W*H)  RA write address
wr_data  output  DATA_W  RA write data
tile_valid  output  1  read bank holds a published tile
tile_release  input  1  consumer finished with the read bank
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State returns to IDLE; row and column counters are 0.
  - All outputs are 0 except tile_req_ready, which is 1.
  - Reset mid-fill abandons the fill with no start_fill pulse. Data still in flight in DRAM is the bench's responsibility; dram_rd_ready is 0.
- FSM states: IDLE, REQ, DATA, SWAP_WAIT, SWAP.
  - IDLE: on tile_req_valid, latch x0, y0, base and stride; set row=0; go to REQ.
  - REQ: drive dram_req_valid with dram_req_addr = frame_base + (y0+row)*stride + x0, computed modulo 2^ADDR_W, and dram_req_len = W. Hold address stable until dram_req_ready; on the handshake, col=0 and go to DATA.
  - DATA: dram_rd_ready=1. On each beat (valid&&ready), register wr_en=1, wr_addr=row*W+col and wr_data for exactly one cycle, then col++. Write latency is 1 cycle from the beat.
  - On the beat with col==W-1: if row==H-1 go to SWAP_WAIT; otherwise row++ and go to REQ.
  - Gaps in dram_rd_valid stall the column counter.
  - SWAP_WAIT: if tile_valid==0, or tile_release is asserted this cycle, go to SWAP. Otherwise hold; a back-to-back prefetch waits here until the consumer releases.
  - SWAP: pulse start_fill for 1 cycle, set tile_valid=1, go to IDLE.
  - The RA sees start_fill one cycle after the last wr_en, so the final write commits before the swap.
- tile_valid:
  - Cleared by tile_release.
  - Set in SWAP. If release and set happen in the same cycle, set wins.
  - tile_release while tile_valid=0 is ignored.
- Exactly W*H wr_en pulses and exactly one start_fill per accepted tile request.
- wr_addr never wraps within a tile; the last address is W*H-1.
- Extra dram_rd_valid outside DATA is not accepted because ready=0.

Optional Feature:
- RA_PREFETCH_PERF_EN defined: adds outputs perf_fill_cycles[31:0] and perf_stall_cycles[31:0].
  - perf_fill_cycles counts cycles in REQ or DATA.
  - perf_stall_cycles counts DATA cycles with dram_rd_valid=0, plus SWAP_WAIT cycles.
  - Both saturate at all-ones and clear on reset only.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ra_pkg:
  - enum ra_pf_state_t {IDLE, REQ, DATA, SWAP_WAIT, SWAP}.
  - struct ra_tile_req_t {x0, y0, base, stride}.
  - localparam for perf counter width 32.
- One sub-module, ra_row_addr_gen: combinational base + (y0+row)*stride + x0 with ADDR_W truncation. Keeps the multiplier isolated for retiming.

Test Plan:
- Single 16x16 tile, base=0x1000, stride=64, x0=8, y0=4, DRAM always ready/valid:
  - 16 requests, addresses 0x1108, 0x1148, ..., 0x14C8.
  - 256 wr_en pulses with addr 0..255 in order.
  - One start_fill one cycle after the last write, then tile_valid=1.
- Back-to-back second request while tile_valid=1:
  - Fill completes and holds in SWAP_WAIT with no start_fill.
  - tile_release -> start_fill the next cycle; tile_valid stays 1.
- dram_req_ready low for 5 cycles, plus random dram_rd_valid gaps:
  - Address held stable while unaccepted.
  - wr_addr sequence contiguous with no duplicates.
  - perf_stall_cycles equals injected gap count (PERF_EN build).
- Address wrap: base=0xFFFFFF00, stride=256, y0=1 -> row-0 address wraps to 0x00000000 + x0.
- rst_n=0 at row 7, col 3:
  - Next cycle: wr_en=0, start_fill never pulses, tile_valid=0, tile_req_ready=1.
  - A new request then fills cleanly.
- tile_release asserted with tile_valid=0 -> no state change; the following fill swaps immediately without waiting.
